// File: rtl/counter_sequencer.sv
// counter_sequencer: run/pause/stop controller for an external prescaled counter.
// Owns the prescaler, drives the counter's CE and synchronous clear, and compares
// the counter read-back against a terminal count latched at start.
// Every output is decoded from registered state, the latched configuration and
// COUNT, so START/STOP/DIV/LIMIT/MODE never reach an output combinationally.

module counter_sequencer #(
    parameter int PRESCALE_WIDTH = 22,
    parameter int COUNT_WIDTH    = 8
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      START,
    input  logic                      STOP,
    input  logic                      MODE,
    input  logic [PRESCALE_WIDTH-1:0] DIV,
    input  logic [COUNT_WIDTH-1:0]    LIMIT,
    input  logic [COUNT_WIDTH-1:0]    COUNT,
    output logic                      CE,
    output logic                      CLR,
    output logic                      BUSY,
    output logic                      DONE
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    localparam logic [PRESCALE_WIDTH-1:0] PRESC_ZERO = '0;
    localparam logic [PRESCALE_WIDTH-1:0] PRESC_ONE  = PRESCALE_WIDTH'(1);

    state_t                    state_reg, state_next;
    logic [PRESCALE_WIDTH-1:0] presc_reg, presc_next;
    logic [PRESCALE_WIDTH-1:0] div_reg,   div_next;
    logic [COUNT_WIDTH-1:0]    limit_reg, limit_next;
    logic                      mode_reg,  mode_next;
    // Abort from PAUSE returns to IDLE and clears the counter in the first
    // IDLE cycle; holding that request in a register keeps STOP off the CLR path.
    logic                      abort_clr_reg, abort_clr_next;

    logic tick;
    logic at_limit;
    logic terminal;

    // Prescaler wraps when it reaches the latched divisor; compare never overshoots
    // because the prescaler resets to zero on the matching cycle.
    assign tick     = (state_reg == RUN) && (presc_reg == div_reg);
    assign at_limit = (COUNT == limit_reg);
    assign terminal = tick && at_limit;

    // Registered state, prescaler and latched configuration.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg     <= IDLE;
            presc_reg     <= PRESC_ZERO;
            div_reg       <= '0;
            limit_reg     <= '0;
            mode_reg      <= 1'b0;
            abort_clr_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            presc_reg     <= presc_next;
            div_reg       <= div_next;
            limit_reg     <= limit_next;
            mode_reg      <= mode_next;
            abort_clr_reg <= abort_clr_next;
        end
    end

    // Next-state, prescaler advance and configuration capture.
    always_comb begin
        state_next     = state_reg;
        presc_next     = presc_reg;
        div_next       = div_reg;
        limit_next     = limit_reg;
        mode_next      = mode_reg;
        abort_clr_next = 1'b0;

        case (state_reg)
            IDLE: begin
                // STOP has priority over START: both high means stay idle.
                if (START && !STOP) begin
                    state_next = CLEAR;
                    div_next   = DIV;
                    limit_next = LIMIT;
                    mode_next  = MODE;
                    presc_next = PRESC_ZERO;
                end
            end

            CLEAR: begin
                // Single clear cycle; START/STOP deliberately not examined.
                state_next = RUN;
                presc_next = PRESC_ZERO;
            end

            RUN: begin
                if (terminal && !mode_reg) begin
                    // One-shot finished: the run is over regardless of STOP.
                    state_next = IDLE;
                    presc_next = PRESC_ZERO;
                end else if (STOP) begin
                    // Pause keeps the prescaler phase so resume continues it.
                    state_next = PAUSE;
                end else if (tick) begin
                    presc_next = PRESC_ZERO;
                end else begin
                    presc_next = presc_reg + PRESC_ONE;
                end
            end

            PAUSE: begin
                if (STOP) begin
                    state_next     = IDLE;
                    presc_next     = PRESC_ZERO;
                    abort_clr_next = 1'b1;
                end else if (START) begin
                    state_next = RUN;
                end
            end

            default: begin
                state_next = IDLE;
                presc_next = PRESC_ZERO;
            end
        endcase
    end

    // Output decode: CE only on a non-terminal tick, CLR for the clear cycle, the
    // auto-reload wrap and the abort; the two conditions are mutually exclusive.
    always_comb begin
        CE   = tick && !at_limit;
        DONE = terminal;
        CLR  = (state_reg == CLEAR) || (terminal && mode_reg) || abort_clr_reg;
        BUSY = (state_reg != IDLE);
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural 8-bit counter as the
// controlled datapath. Inputs change 1 time unit after a rising edge; outputs
// are sampled at that same point, after all registered values have settled.

module tb_counter_sequencer;

    localparam int PW = 22;
    localparam int CW = 8;

    logic          CLK   = 1'b0;
    logic          RESET = 1'b0;
    logic          START = 1'b0;
    logic          STOP  = 1'b0;
    logic          MODE  = 1'b0;
    logic [PW-1:0] DIV   = '0;
    logic [CW-1:0] LIMIT = '0;
    logic [CW-1:0] COUNT;
    logic          CE, CLR, BUSY, DONE;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    counter_sequencer #(
        .PRESCALE_WIDTH (PW),
        .COUNT_WIDTH    (CW)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .START (START),
        .STOP  (STOP),
        .MODE  (MODE),
        .DIV   (DIV),
        .LIMIT (LIMIT),
        .COUNT (COUNT),
        .CE    (CE),
        .CLR   (CLR),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    // Controlled counter: own async reset, sync clear, count enable.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)   COUNT <= '0;
        else if (CLR) COUNT <= '0;
        else if (CE)  COUNT <= COUNT + 8'd1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Abort from PAUSE: CLR for one cycle while BUSY is already low, then counter zero.
    task automatic stop_from_pause(input string tag);
        STOP = 1'b1;
        cyc();
        STOP = 1'b0;
        check({tag, "_abort_busy"}, BUSY, 0);
        check({tag, "_abort_clr"},  CLR,  1);
        check({tag, "_abort_ce"},   CE,   0);
        cyc();
        check({tag, "_post_clr"},   CLR,   0);
        check({tag, "_post_count"}, COUNT, 0);
    endtask

    initial begin
        int ce_cnt;
        int done_cnt;
        int busy_cnt;
        int last_count;

        // ---------------- reset state ----------------
        #12;
        check("rst_busy", BUSY, 0);
        check("rst_ce",   CE,   0);
        check("rst_clr",  CLR,  0);
        check("rst_done", DONE, 0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        cyc();
        check("rst_rel_busy", BUSY, 0);

        // ---------------- T1: one-shot DIV=2 LIMIT=3 ----------------
        MODE = 1'b0; DIV = 22'd2; LIMIT = 8'd3; START = 1'b1;
        cyc();
        START = 1'b0;
        check("t1_clear_clr",  CLR,  1);
        check("t1_clear_busy", BUSY, 1);
        check("t1_clear_ce",   CE,   0);
        ce_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            check($sformatf("t1_ce_c%0d", i),   CE,   (i % 3 == 0) && (i < 12));
            check($sformatf("t1_done_c%0d", i), DONE, (i == 12));
            check($sformatf("t1_busy_c%0d", i), BUSY, 1);
            ce_cnt += int'(CE);
        end
        check("t1_ce_total", ce_cnt, 3);
        check("t1_count_at_done", COUNT, 3);
        cyc();
        check("t1_busy_fall", BUSY,  0);
        check("t1_count_hold", COUNT, 3);
        $display("T1 one-shot DIV=2 LIMIT=3 done, checks=%0d", checks);

        // ---------------- T2: auto-reload DIV=0 LIMIT=0 ----------------
        MODE = 1'b1; DIV = 22'd0; LIMIT = 8'd0; START = 1'b1;
        cyc();
        START = 1'b0;
        check("t2_clear_clr", CLR, 1);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            check($sformatf("t2_ce_c%0d", i),   CE,   0);
            check($sformatf("t2_done_c%0d", i), DONE, 1);
            check($sformatf("t2_clr_c%0d", i),  CLR,  1);
            check($sformatf("t2_busy_c%0d", i), BUSY, 1);
        end
        STOP = 1'b1;
        cyc();
        STOP = 1'b0;
        check("t2_pause_busy", BUSY, 1);
        check("t2_pause_clr",  CLR,  0);
        check("t2_pause_done", DONE, 0);
        stop_from_pause("t2");
        $display("T2 auto-reload DIV=0 LIMIT=0 done, checks=%0d", checks);

        // ---------------- T3: auto-reload DIV=1 LIMIT=2 ----------------
        MODE = 1'b1; DIV = 22'd1; LIMIT = 8'd2; START = 1'b1;
        cyc();
        START = 1'b0;
        check("t3_clear_clr", CLR, 1);
        for (int i = 1; i <= 18; i++) begin
            cyc();
            check($sformatf("t3_ce_c%0d", i),   CE,   (i % 2 == 0) && ((i / 2) % 3 != 0));
            check($sformatf("t3_done_c%0d", i), DONE, (i % 2 == 0) && ((i / 2) % 3 == 0));
            check($sformatf("t3_clr_c%0d", i),  CLR,  (i % 2 == 0) && ((i / 2) % 3 == 0));
            check($sformatf("t3_excl_c%0d", i), CE & CLR, 0);
        end
        STOP = 1'b1;
        cyc();
        STOP = 1'b0;
        check("t3_pause_busy", BUSY, 1);
        stop_from_pause("t3");
        $display("T3 auto-reload DIV=1 LIMIT=2 done, checks=%0d", checks);

        // ---------------- T4: pause/resume phase, DIV=4 ----------------
        MODE = 1'b1; DIV = 22'd4; LIMIT = 8'd5; START = 1'b1;
        cyc();                      // CLEAR
        START = 1'b0;
        cyc();                      // RUN, prescaler 0
        cyc();                      // RUN, prescaler 1
        cyc();                      // RUN, prescaler 2
        check("t4_pre_stop_ce", CE, 0);
        STOP = 1'b1;
        cyc();                      // PAUSE with prescaler 2
        STOP = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            check($sformatf("t4_pause_ce_c%0d", i),   CE,   0);
            check($sformatf("t4_pause_busy_c%0d", i), BUSY, 1);
            check($sformatf("t4_pause_clr_c%0d", i),  CLR,  0);
            cyc();
        end
        START = 1'b1;
        cyc();                      // RUN resumed, prescaler 2
        START = 1'b0;
        check("t4_resume0_ce", CE, 0);
        cyc();                      // prescaler 3
        check("t4_resume1_ce", CE, 0);
        cyc();                      // prescaler 4: tick
        check("t4_resume2_ce",  CE,    1);
        check("t4_resume_count", COUNT, 0);
        cyc();
        check("t4_count_after", COUNT, 1);
        STOP = 1'b1;
        cyc();
        STOP = 1'b0;
        check("t4_pause2_busy", BUSY, 1);
        stop_from_pause("t4");
        $display("T4 pause/resume DIV=4 done, checks=%0d", checks);

        // ---------------- T5: simultaneous START and STOP ----------------
        MODE = 1'b1; DIV = 22'd0; LIMIT = 8'd10;
        START = 1'b1; STOP = 1'b1;
        cyc();
        check("t5_idle_busy0", BUSY, 0);
        check("t5_idle_clr0",  CLR,  0);
        cyc();
        check("t5_idle_busy1", BUSY, 0);
        check("t5_idle_clr1",  CLR,  0);
        STOP = 1'b0;
        cyc();                      // CLEAR
        START = 1'b0;
        cyc();                      // RUN 1
        check("t5_run1_ce", CE, 1);
        cyc();                      // RUN 2
        check("t5_run2_ce", CE, 1);
        START = 1'b1; STOP = 1'b1;
        cyc();                      // PAUSE
        START = 1'b0; STOP = 1'b0;
        check("t5_pause_busy",  BUSY,  1);
        check("t5_pause_ce",    CE,    0);
        check("t5_pause_count", COUNT, 2);
        cyc();
        check("t5_pause_ce2",    CE,    0);
        check("t5_pause_count2", COUNT, 2);
        stop_from_pause("t5");
        $display("T5 simultaneous START/STOP done, checks=%0d", checks);

        // ---------------- T6a: async reset mid-RUN ----------------
        MODE = 1'b1; DIV = 22'd0; LIMIT = 8'd10; START = 1'b1;
        cyc();                      // CLEAR
        START = 1'b0;
        cyc();
        cyc();
        check("t6_run_ce",   CE,   1);
        check("t6_run_busy", BUSY, 1);
        #2;
        RESET = 1'b0;
        #1;
        check("t6_async_ce",   CE,   0);
        check("t6_async_clr",  CLR,  0);
        check("t6_async_busy", BUSY, 0);
        check("t6_async_done", DONE, 0);
        #2;
        RESET = 1'b1;
        cyc();
        check("t6_post_busy", BUSY, 0);
        check("t6_post_ce",   CE,   0);

        // ---------------- T6b: config change while busy ----------------
        MODE = 1'b1; DIV = 22'd1; LIMIT = 8'd100; START = 1'b1;
        cyc();                      // CLEAR
        START = 1'b0;
        DIV = 22'd0; LIMIT = 8'd0; MODE = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            check($sformatf("t6_cfg_ce_c%0d", i),   CE,   (i % 2 == 0));
            check($sformatf("t6_cfg_done_c%0d", i), DONE, 0);
        end
        check("t6_cfg_count", COUNT, 3);
        STOP = 1'b1;
        cyc();
        STOP = 1'b0;
        check("t6_cfg_pause_busy", BUSY, 1);
        stop_from_pause("t6");
        $display("T6 async reset and config hold done, checks=%0d", checks);

        // ---------------- T7: maximum LIMIT, one-shot DIV=0 ----------------
        MODE = 1'b0; DIV = 22'd0; LIMIT = 8'd255; START = 1'b1;
        busy_cnt = 0; ce_cnt = 0; done_cnt = 0; last_count = -1;
        for (int n = 0; n < 400; n++) begin
            cyc();
            START = 1'b0;
            if (!BUSY) break;
            busy_cnt++;
            ce_cnt   += int'(CE);
            done_cnt += int'(DONE);
            if (DONE) last_count = int'(COUNT);
        end
        check("t7_busy_span",  busy_cnt,   257);
        check("t7_ce_total",   ce_cnt,     255);
        check("t7_done_total", done_cnt,   1);
        check("t7_done_count", last_count, 255);
        check("t7_final_count", COUNT,     255);
        $display("T7 LIMIT=255 one-shot done, checks=%0d", checks);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
